// File: rtl/qspi_ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM state codes and command legality check.
package qspi_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // ERROR, RETRY and SPLIT are all handled as an error response
    localparam logic [1:0] HRESP_OKAY = 2'b00;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_BURST = 3'd2;
    localparam logic [2:0] ST_LAST  = 3'd3;
    localparam logic [2:0] ST_ERR1  = 3'd4;

    // A command is legal if size is byte/half/word, beats in range, address aligned
    function automatic logic cmd_legal(input logic [1:0]  addr_lo,
                                       input logic [1:0]  size,
                                       input logic [31:0] beats,
                                       input logic [31:0] max_beats);
        logic ok;
        ok = 1'b1;
        if (size == 2'd3) ok = 1'b0;
        if (beats == 32'd0 || beats > max_beats) ok = 1'b0;
        if ({1'b0, size} == HSIZE_HALF && addr_lo[0]) ok = 1'b0;
        if ({1'b0, size} == HSIZE_WORD && addr_lo != 2'b00) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/qspi_ahb_addr_gen.sv
// Incrementing AHB address generator with 1KB-boundary detection.
module qspi_ahb_addr_gen (
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    output logic [31:0] next_o,
    output logic        cross_1k_o
);

    // Next beat address and whether it starts a new 1KB page
    always_comb begin
        next_o     = addr_i + (32'd1 << size_i);
        cross_1k_o = (next_o[9:0] == 10'd0);
    end

endmodule

// File: rtl/qspi_ahb_master_itf.sv
// AHB-Lite master: one command becomes a SINGLE/INCR transfer with pipelined
// address/data phases, BUSY on write-data stalls, NSEQ at 1KB pages and
// two-cycle error cancel.
module qspi_ahb_master_itf
    import qspi_ahb_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int BEAT_W    = 5
) (
    input  logic              hclk_i,
    input  logic              hreset_i,
    input  logic              cmd_val_i,
    output logic              cmd_rdy_o,
    input  logic [31:0]       cmd_addr_i,
    input  logic              cmd_rd_i,
    input  logic [1:0]        cmd_size_i,
    input  logic [BEAT_W-1:0] cmd_beats_i,
    input  logic              wdat_val_i,
    output logic              wdat_rdy_o,
    input  logic [31:0]       wdat_i,
    output logic              rdat_val_o,
    output logic [31:0]       rdat_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic [31:0]       hwdata_o,
    input  logic              hready_i,
    input  logic [1:0]        hresp_i,
    input  logic [31:0]       hrdata_i
);

    logic [2:0]        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [BEAT_W-1:0] rem_q, rem_d;
    logic              first_q, first_d, bnd_q, bnd_d, rd_q, rd_d, dp_q, dp_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [31:0]       haddr_q, haddr_d, hwdata_q, hwdata_d, rdat_q, rdat_d;
    logic              hwrite_q, hwrite_d, rdat_val_q, rdat_val_d;
    logic              done_q, done_d, err_q, err_d;
    logic [2:0]        hsize_q, hsize_d, hburst_q, hburst_d;

    logic [31:0]       s_addr, g_next;
    logic [1:0]        s_size;
    logic [BEAT_W-1:0] s_rem;
    logic              s_first, s_bnd, s_rd, s_data, g_cross;
    logic              legal, do_slot, wdat_rdy;

    // In IDLE the issue slot works straight from the command so a read's NSEQ
    // appears the cycle after accept; otherwise it works from the held command.
    always_comb begin
        if (state_q == ST_IDLE) begin
            s_addr  = cmd_addr_i;
            s_size  = cmd_size_i;
            s_rem   = cmd_beats_i;
            s_first = 1'b1;
            s_bnd   = 1'b0;
            s_rd    = cmd_rd_i;
        end else begin
            s_addr  = addr_q;
            s_size  = size_q;
            s_rem   = rem_q;
            s_first = first_q;
            s_bnd   = bnd_q;
            s_rd    = rd_q;
        end
        s_data = s_rd | (wdat_val_i & (state_q != ST_IDLE));
        legal  = cmd_legal(cmd_addr_i[1:0], cmd_size_i, 32'(cmd_beats_i), 32'(MAX_BEATS));
    end

    qspi_ahb_addr_gen u_addr_gen (
        .addr_i     (s_addr),
        .size_i     (s_size),
        .next_o     (g_next),
        .cross_1k_o (g_cross)
    );

    // FSM, beat issue, data-phase completion and error handling
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        first_d    = first_q;
        bnd_d      = bnd_q;
        rd_d       = rd_q;
        dp_d       = dp_q;
        size_d     = size_q;
        wbuf_d     = wbuf_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        rdat_d     = rdat_q;
        rdat_val_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wdat_rdy   = 1'b0;
        do_slot    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_val_i) begin
                    if (!legal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        rd_d     = cmd_rd_i;
                        size_d   = cmd_size_i;
                        addr_d   = cmd_addr_i;
                        rem_d    = cmd_beats_i;
                        first_d  = 1'b1;
                        bnd_d    = 1'b0;
                        hwrite_d = ~cmd_rd_i;
                        hsize_d  = {1'b0, cmd_size_i};
                        hburst_d = (cmd_beats_i == BEAT_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
                        state_d  = ST_ADDR;
                        do_slot  = 1'b1;
                    end
                end
            end
            ST_ADDR, ST_BURST, ST_LAST: begin
                if (dp_q && hresp_i != HRESP_OKAY) begin
                    htrans_d = HTRANS_IDLE;
                    rem_d    = '0;
                    if (hready_i) begin
                        dp_d    = 1'b0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else if (hready_i) begin
                    if (dp_q && !hwrite_q) begin
                        rdat_d     = hrdata_i;
                        rdat_val_d = 1'b1;
                    end
                    dp_d = htrans_q[1];
                    if (htrans_q[1]) hwdata_d = wbuf_q;
                    if (state_q == ST_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        do_slot = 1'b1;
                    end
                end
            end
            ST_ERR1: begin
                htrans_d = HTRANS_IDLE;
                if (hready_i) begin
                    dp_d    = 1'b0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Next address phase: a beat if data is available, else BUSY (IDLE before the first beat)
        if (do_slot) begin
            if (s_rem != '0) begin
                if (s_data) begin
                    htrans_d = (s_first || s_bnd) ? HTRANS_NSEQ : HTRANS_SEQ;
                    haddr_d  = s_addr;
                    addr_d   = g_next;
                    bnd_d    = g_cross;
                    rem_d    = s_rem - BEAT_W'(1);
                    first_d  = 1'b0;
                    if (!s_rd) begin
                        wdat_rdy = 1'b1;
                        wbuf_d   = wdat_i;
                    end
                end else begin
                    htrans_d = s_first ? HTRANS_IDLE : HTRANS_BUSY;
                    if (!s_first) haddr_d = s_addr;
                end
            end else begin
                htrans_d = HTRANS_IDLE;
            end
            if (state_q != ST_IDLE) begin
                if (state_q == ST_ADDR && !htrans_q[1])
                    state_d = ST_ADDR;
                else if (rem_d == '0 && !htrans_d[1])
                    state_d = ST_LAST;
                else
                    state_d = ST_BURST;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            bnd_q      <= 1'b0;
            rd_q       <= 1'b0;
            dp_q       <= 1'b0;
            size_q     <= '0;
            wbuf_q     <= '0;
            htrans_q   <= HTRANS_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
            hburst_q   <= HBURST_SINGLE;
            hwdata_q   <= '0;
            rdat_q     <= '0;
            rdat_val_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            bnd_q      <= bnd_d;
            rd_q       <= rd_d;
            dp_q       <= dp_d;
            size_q     <= size_d;
            wbuf_q     <= wbuf_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            rdat_q     <= rdat_d;
            rdat_val_q <= rdat_val_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_rdy_o  = (state_q == ST_IDLE);
    assign wdat_rdy_o = wdat_rdy;
    assign rdat_val_o = rdat_val_q;
    assign rdat_o     = rdat_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign haddr_o    = haddr_q;
    assign htrans_o   = htrans_q;
    assign hwrite_o   = hwrite_q;
    assign hsize_o    = hsize_q;
    assign hburst_o   = hburst_q;
    assign hwdata_o   = hwdata_q;

endmodule
